// File: rtl/yuv422_to_yuv444.sv
// yuv422_to_yuv444
//   Chroma upsampler from a 16-bit YUV 4:2:2 stream to 8:8:8 Y/U/V per pixel.
//   Every input signal takes a fixed 4 clk to reach the outputs. Odd pixels
//   can interpolate chroma from the next pair. A short window of samples
//   that have already arrived supplies that lookahead.
//
// Parameters
//   INTERP   : 1 = odd-pixel chroma is the rounded average of pairs k and k+1,
//              0 = odd pixel repeats the chroma of its own pair
//   CB_FIRST : 1 = even pixel carries Cb and odd pixel carries Cr, 0 = swapped
//
// Ports
//   clk, rst_n        : pixel clock, asynchronous active-low reset
//   per_img_vsync/href/deo : input sync and data enable
//   per_img_data      : [15:8] Y, [7:0] chroma sample (Cb or Cr by phase)
//   post_img_vsync/href/deo : syncs delayed 4 clk
//   post_img_y/u/v    : luma, Cb, Cr (all zero while post_img_deo is low)
module yuv422_to_yuv444 #(
    parameter int unsigned INTERP   = 1,
    parameter int unsigned CB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_img_vsync,
    input  logic        per_img_href,
    input  logic        per_img_deo,
    input  logic [15:0] per_img_data,
    output logic        post_img_vsync,
    output logic        post_img_href,
    output logic        post_img_deo,
    output logic [7:0]  post_img_y,
    output logic [7:0]  post_img_u,
    output logic [7:0]  post_img_v
);

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_e;

    typedef struct packed {
        logic       vs;
        logic       hr;
        logic       de;
        phase_e     ph;
        logic [7:0] y;
        logic [7:0] c;
    } samp_t;

    // Window of samples. Index 0 holds the newest sample and index 4 the
    // oldest. Index 3 is the pixel being emitted. Indices 2 and 1 are the
    // next two pixels (lookahead), and index 4 is the previous pixel, which
    // holds the even-slot chroma of an odd pixel's pair.
    localparam int unsigned DEPTH = 5;

    phase_e      phase_q, phase_d;
    samp_t       in_s;
    samp_t       pipe_q [DEPTH];

    logic        vsync_q, href_q, deo_q;
    logic [7:0]  y_q, u_q, v_q;
    logic [7:0]  y_d, u_d, v_d;
    logic [7:0]  slot_a;   // chroma belonging to the even position of the pair
    logic [7:0]  slot_b;   // chroma belonging to the odd position of the pair

    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 9'd1;
        return sum[8:1];
    endfunction

    always_comb begin
        phase_d = PH_EVEN;
        if (per_img_deo) begin
            phase_d = (phase_q == PH_EVEN) ? PH_ODD : PH_EVEN;
        end
        in_s.vs = per_img_vsync;
        in_s.hr = per_img_href;
        in_s.de = per_img_deo;
        in_s.ph = phase_q;
        in_s.y  = per_img_data[15:8];
        in_s.c  = per_img_data[7:0];
    end

    // A de=1 window neighbour of the current pixel belongs to the same run
    // only if no de=0 sample lies between them. So the second lookahead
    // (index 1) also depends on index 2 being valid.
    always_comb begin
        slot_a = pipe_q[3].c;
        slot_b = 8'd128;
        if (pipe_q[3].ph == PH_EVEN) begin
            if (pipe_q[2].de) begin
                slot_b = pipe_q[2].c;
            end
        end else begin
            slot_a = pipe_q[4].c;
            slot_b = pipe_q[3].c;
            if (INTERP != 0) begin
                if (pipe_q[2].de) begin
                    slot_a = avg8(pipe_q[4].c, pipe_q[2].c);
                end
                if (pipe_q[2].de && pipe_q[1].de) begin
                    slot_b = avg8(pipe_q[3].c, pipe_q[1].c);
                end
            end
        end

        y_d = '0;
        u_d = '0;
        v_d = '0;
        if (pipe_q[3].de) begin
            y_d = pipe_q[3].y;
            u_d = (CB_FIRST != 0) ? slot_a : slot_b;
            v_d = (CB_FIRST != 0) ? slot_b : slot_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_EVEN;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            deo_q   <= 1'b0;
            y_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
        end else begin
            phase_q   <= phase_d;
            pipe_q[0] <= in_s;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            vsync_q <= pipe_q[3].vs;
            href_q  <= pipe_q[3].hr;
            deo_q   <= pipe_q[3].de;
            y_q     <= y_d;
            u_q     <= u_d;
            v_q     <= v_d;
        end
    end

    assign post_img_vsync = vsync_q;
    assign post_img_href  = href_q;
    assign post_img_deo   = deo_q;
    assign post_img_y     = y_q;
    assign post_img_u     = u_q;
    assign post_img_v     = v_q;

endmodule

// File: tb/tb_yuv422_to_yuv444.sv
// Testbench for yuv422_to_yuv444: three configurations share one stimulus
// stream. A line-based reference model checks every output cycle.
module tb_yuv422_to_yuv444;

    localparam int MAXN = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs_i = 1'b0, hr_i = 1'b0, de_i = 1'b0;
    logic [15:0] data_i = '0;

    logic        a_vs, a_hr, a_de; logic [7:0] a_y, a_u, a_v;   // INTERP=1 CB_FIRST=1
    logic        r_vs, r_hr, r_de; logic [7:0] r_y, r_u, r_v;   // INTERP=0 CB_FIRST=1
    logic        s_vs, s_hr, s_de; logic [7:0] s_y, s_u, s_v;   // INTERP=1 CB_FIRST=0

    int n_assert = 0;
    int n_fail   = 0;

    // stimulus stream
    bit   st_vs [MAXN];
    bit   st_hr [MAXN];
    bit   st_de [MAXN];
    logic [7:0] st_y [MAXN];
    logic [7:0] st_c [MAXN];
    int   n = 0;

    logic [26:0] cap_a [MAXN];
    logic [26:0] cap_r [MAXN];

    always #5 clk = ~clk;

    yuv422_to_yuv444 #(.INTERP(1), .CB_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .per_img_vsync(vs_i), .per_img_href(hr_i), .per_img_deo(de_i), .per_img_data(data_i),
        .post_img_vsync(a_vs), .post_img_href(a_hr), .post_img_deo(a_de),
        .post_img_y(a_y), .post_img_u(a_u), .post_img_v(a_v));

    yuv422_to_yuv444 #(.INTERP(0), .CB_FIRST(1)) dut_r (
        .clk(clk), .rst_n(rst_n),
        .per_img_vsync(vs_i), .per_img_href(hr_i), .per_img_deo(de_i), .per_img_data(data_i),
        .post_img_vsync(r_vs), .post_img_href(r_hr), .post_img_deo(r_de),
        .post_img_y(r_y), .post_img_u(r_u), .post_img_v(r_v));

    yuv422_to_yuv444 #(.INTERP(1), .CB_FIRST(0)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .per_img_vsync(vs_i), .per_img_href(hr_i), .per_img_deo(de_i), .per_img_data(data_i),
        .post_img_vsync(s_vs), .post_img_href(s_hr), .post_img_deo(s_de),
        .post_img_y(s_y), .post_img_u(s_u), .post_img_v(s_v));

    task automatic push(input bit vs, input bit hr, input bit de, input int y, input int c);
        st_vs[n] = vs; st_hr[n] = hr; st_de[n] = de;
        st_y[n] = y[7:0]; st_c[n] = c[7:0];
        n++;
    endtask

    task automatic push_line(input int ys[], input int cs[]);
        for (int i = 0; i < cs.size(); i++) push(1'b0, 1'b1, 1'b1, ys[i], cs[i]);
    endtask

    task automatic push_gap(input int len);
        for (int i = 0; i < len; i++) push(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Expected {vsync, href, de, y, u, v} for the input sampled at stream index idx.
    // Works on whole de runs: finds the run, splits it into pairs and applies
    // the chroma rules by position within the line.
    function automatic logic [26:0] model(input int idx, input bit interp, input bit cbf);
        int s, e, len, p, k, a, b;
        if (idx < 0) return '0;
        if (!st_de[idx]) return {st_vs[idx], st_hr[idx], 1'b0, 24'd0};
        s = idx;
        while (s > 0 && st_de[s-1]) s--;
        e = idx;
        while (e < n - 1 && st_de[e+1]) e++;
        len = e - s + 1;
        p = idx - s;
        k = p / 2;
        a = int'(st_c[s + 2*k]);
        b = (2*k + 1 < len) ? int'(st_c[s + 2*k + 1]) : 128;
        if ((p % 2 == 1) && interp) begin
            if (2*k + 2 < len) a = (a + int'(st_c[s + 2*k + 2]) + 1) / 2;
            if (2*k + 3 < len) b = (b + int'(st_c[s + 2*k + 3]) + 1) / 2;
        end
        if (cbf) return {st_vs[idx], st_hr[idx], 1'b1, st_y[idx], a[7:0], b[7:0]};
        else     return {st_vs[idx], st_hr[idx], 1'b1, st_y[idx], b[7:0], a[7:0]};
    endfunction

    task automatic check(input string tag, input int idx, input logic [26:0] obs, input logic [26:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s idx=%0d observed={vs,hr,de,y,u,v}=%h required=%h", tag, idx, obs, exp);
        end
    endtask

    task automatic check_yuv(input string tag, input logic [26:0] obs, input int y, input int u, input int v);
        logic [23:0] exp;
        exp = {y[7:0], u[7:0], v[7:0]};
        n_assert++;
        assert (obs[23:0] === exp) else begin
            n_fail++;
            $error("FAIL %s observed y/u/v=%0d/%0d/%0d required %0d/%0d/%0d",
                   tag, obs[23:16], obs[15:8], obs[7:0], y, u, v);
        end
    endtask

    int la, lodd, lr1, lr2, lr3, lb1, lb2;

    initial begin
        // ---------------- stimulus construction ----------------
        push_gap(3);
        la = n;   push_line('{10, 11, 12, 13, 14, 15}, '{100, 200, 120, 210, 140, 220});
        push_gap(3);
        lr1 = n;  push_line('{30, 31, 32, 33}, '{1, 5, 2, 7});
        push_gap(1);
        lr2 = n;  push_line('{40, 41, 42, 43}, '{255, 9, 255, 9});
        push_gap(2);
        lr3 = n;  push_line('{50, 51, 52, 53}, '{0, 9, 255, 9});
        push_gap(2);
        lodd = n; push_line('{20, 21, 22}, '{50, 60, 70});
        push_gap(4);
        lb1 = n;  push_line('{60, 61, 62, 63}, '{10, 20, 30, 40});
        push_gap(1);
        lb2 = n;  push_line('{70, 71, 72, 73}, '{250, 240, 230, 220});
        push_gap(1);
        push(1'b1, 1'b1, 1'b1, 99, 77);              // single-pixel line
        push(1'b1, 1'b0, 1'b0, 0, 0);
        push_line('{80, 81}, '{33, 44});              // gapless restart follows
        push_gap(1);
        while (n < 440) begin
            int gap, len;
            gap = $urandom_range(1, 4);
            len = $urandom_range(1, 12);
            for (int i = 0; i < gap; i++)
                push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0, 0);
            for (int i = 0; i < len; i++)
                push(1'($urandom_range(0, 1)), 1'b1, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255));
        end
        push_gap(2);

        // ---------------- reset state ----------------
        @(negedge clk);
        check("reset_a", -1, {a_vs, a_hr, a_de, a_y, a_u, a_v}, '0);
        check("reset_r", -1, {r_vs, r_hr, r_de, r_y, r_u, r_v}, '0);
        check("reset_s", -1, {s_vs, s_hr, s_de, s_y, s_u, s_v}, '0);
        rst_n = 1'b1;

        // ---------------- mid-line reset (5 pixels -> phase left odd) ----------------
        for (int j = 0; j < 5; j++) begin
            vs_i = 1'b1; hr_i = 1'b1; de_i = 1'b1;
            data_i = {8'(8'h40 + j), 8'(8'h10 * (j + 1))};
            @(negedge clk);
        end
        // first pixel emerges exactly 4 edges after it was sampled
        check_yuv("pre_reset_pix0", {a_vs, a_hr, a_de, a_y, a_u, a_v}, 8'h40, 8'h10, 8'h20);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_a", -1, {a_vs, a_hr, a_de, a_y, a_u, a_v}, '0);
        check("midreset_r", -1, {r_vs, r_hr, r_de, r_y, r_u, r_v}, '0);
        check("midreset_s", -1, {s_vs, s_hr, s_de, s_y, s_u, s_v}, '0);
        vs_i = 1'b0; hr_i = 1'b0; de_i = 1'b0; data_i = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- stream; first stream cycle is a de start right after release ----------------
        st_de[0] = 1'b1; st_hr[0] = 1'b1; st_y[0] = 8'd5; st_c[0] = 8'd90;
        st_de[1] = 1'b1; st_hr[1] = 1'b1; st_y[1] = 8'd6; st_c[1] = 8'd91;
        for (int i = 0; i < n + 5; i++) begin
            int idx;
            idx = i - 5;
            check("stream_i1c1", idx, {a_vs, a_hr, a_de, a_y, a_u, a_v}, model(idx, 1'b1, 1'b1));
            check("stream_i0c1", idx, {r_vs, r_hr, r_de, r_y, r_u, r_v}, model(idx, 1'b0, 1'b1));
            check("stream_i1c0", idx, {s_vs, s_hr, s_de, s_y, s_u, s_v}, model(idx, 1'b1, 1'b0));
            if (idx >= 0) begin
                cap_a[idx] = {a_vs, a_hr, a_de, a_y, a_u, a_v};
                cap_r[idx] = {r_vs, r_hr, r_de, r_y, r_u, r_v};
            end
            if (i < n) begin
                vs_i = st_vs[i]; hr_i = st_hr[i]; de_i = st_de[i];
                data_i = {st_y[i], st_c[i]};
            end else begin
                vs_i = 1'b0; hr_i = 1'b0; de_i = 1'b0; data_i = '0;
            end
            @(negedge clk);
        end

        // ---------------- directed expectations from fixed tables ----------------
        check_yuv("lineA_p0", cap_a[la+0], 10, 100, 200);
        check_yuv("lineA_p1", cap_a[la+1], 11, 110, 205);
        check_yuv("lineA_p2", cap_a[la+2], 12, 120, 210);
        check_yuv("lineA_p3", cap_a[la+3], 13, 130, 215);
        check_yuv("lineA_p4", cap_a[la+4], 14, 140, 220);
        check_yuv("lineA_p5_last", cap_a[la+5], 15, 140, 220);
        check_yuv("lineA_rep_p1", cap_r[la+1], 11, 100, 200);
        check_yuv("lineA_rep_p3", cap_r[la+3], 13, 120, 210);
        check_yuv("lineA_rep_p2", cap_r[la+2], 12, 120, 210);
        check_yuv("round_1_2", cap_a[lr1+1], 31, 2, 6);
        check_yuv("round_255_255", cap_a[lr2+1], 41, 255, 9);
        check_yuv("round_0_255", cap_a[lr3+1], 51, 128, 9);
        check_yuv("odd3_p0", cap_a[lodd+0], 20, 50, 60);
        check_yuv("odd3_p1", cap_a[lodd+1], 21, 60, 60);
        check_yuv("odd3_p2", cap_a[lodd+2], 22, 70, 128);
        check_yuv("b2b_l1_last", cap_a[lb1+3], 63, 30, 40);
        check_yuv("b2b_l2_p0", cap_a[lb2+0], 70, 250, 240);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/yuv422_to_yuv444.md
Name: yuv422_to_yuv444

Overview:
- Chroma upsampler directly upstream of the YUV-to-RGB converter in the video pipeline.
- Accepts a 16-bit YUV 4:2:2 pixel stream: Y on every pixel, Cb/Cr alternating per pixel.
- Outputs a full 8:8:8 Y/U/V triplet per pixel, with vsync/href/de delayed to match, so the output feeds the converter's per_img_* inputs directly.

Parameters:
- INTERP, 1: 1 = odd-pixel chroma is the rounded average of neighbouring pairs; 0 = replicate the pair's chroma.
- CB_FIRST, 1: 1 = chroma order in a pair is Cb then Cr; 0 = Cr then Cb.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- per_img_vsync  in  1  input vsync
- per_img_href  in  1  input href
- per_img_deo  in  1  input data enable; one pixel per clk while high
- per_img_data  in  16  [15:8] = Y, [7:0] = chroma sample (Cb or Cr by phase)
- post_img_vsync  out  1  vsync delayed 4 clk
- post_img_href  out  1  href delayed 4 clk
- post_img_deo  out  1  de delayed 4 clk
- post_img_y  out  8  luma
- post_img_u  out  8  Cb
- post_img_v  out  8  Cr

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs and all pipeline/sync registers go to 0. The phase flag goes to 0 (even).
- Fixed latency of 4 clk for every signal. The pixel sampled at edge t appears at outputs after edge t+4. There is no backpressure.
- Phase:
  - Cleared whenever per_img_deo = 0.
  - Toggles on every clk with per_img_deo = 1.
  - The first pixel of each de run is even (phase 0).
  - Pixel pair k is pixel 2k (even) and pixel 2k+1 (odd).
- Chroma assignment, with CB_FIRST = 1:
  - The even pixel carries Cb_k and the odd pixel carries Cr_k. CB_FIRST = 0 swaps the roles.
  - Even pixel 2k: u = Cb_k, v = Cr_k (co-sited). Cr_k comes from the next input cycle.
  - Odd pixel 2k+1, INTERP = 0: u = Cb_k, v = Cr_k.
  - Odd pixel 2k+1, INTERP = 1: u = (Cb_k + Cb_{k+1} + 1) >> 1 and v = (Cr_k + Cr_{k+1} + 1) >> 1. Use a 9-bit sum, result bits [8:1]; no overflow.
- Lookahead is at most 2 input cycles; the pipeline depth covers it.
- Line end, when de falls before pair k+1 completes:
  - Next pair absent (de = 0 at pixel 2k+2): odd pixel uses Cb_k / Cr_k unaveraged.
  - Only Cb_{k+1} present (de falls at 2k+3): u averages with Cb_{k+1}; v uses Cr_k unaveraged.
  - Odd-length line (de falls after even pixel 2k): that pixel gets u = Cb_k, v = 8'd128.
- Lookahead never crosses a de gap. Chroma from a new line is never blended into the previous line, even with a 1-cycle blanking gap.
- post_img_y is per_img_data[15:8] delayed 4 clk.
- When post_img_deo = 0, post_img_y/u/v are forced to 0.
- vsync and href pass through the same 4-stage delay. They do not affect phase; only de does.
- A de pulse of 1 clk is an odd-length line of 1 pixel: u = C, v = 128.
- Reset asserted mid-line: outputs go to 0 immediately. After release, data is invalid until the next de rising edge, which restarts phase at even.

Test Plan:
- Reset check: assert rst_n low mid-frame -> all outputs 0 immediately. After release, the first de run starts at phase 0 and the 4-clk latency is exact.
- INTERP=1, CB_FIRST=1, line data {Y,C} = {10,100},{11,200},{12,120},{13,210},{14,140},{15,220} -> outputs:
  - (y,u,v) = (10,100,200), (11,110,205), (12,120,210), (13,130,215), (14,140,220), (15,140,220).
  - The last pixel is unaveraged.
- Same stimulus with INTERP=0 -> (11,100,200) for pixel 1 and (13,120,210) for pixel 3. Even pixels are unchanged.
- Rounding: Cb_k = 1, Cb_{k+1} = 2 -> odd u = 2. Cb 255/255 -> 255. Cb 0/255 -> 128.
- Odd-length line of 3 pixels {20,50},{21,60},{22,70} (INTERP=1) -> (20,50,60), (21,60,60), (22,70,128).
- Back-to-back lines with a 1-clk de gap -> the last odd pixel of line 1 is not averaged with line 2 chroma. Line 2 pixel 0 uses its own Cb/Cr. vsync/href/de outputs equal the inputs delayed exactly 4 clk.
